inst_mem_pipe: RTL

- Parametrised, pipelined successor to the single-cycle instruction ROM.
- Synchronous-read instruction memory with a valid/ready fetch interface and configurable read latency (1-4 cycles).
- Reports misaligned-address and out-of-range faults, and provides a word-write load port for program bootloading.
- Sits between the fetch/PC stage and the decode stage of the pipelined CPU.

---
 rtl/inst_mem_pipe_if.sv | 38 +++
 rtl/inst_mem_pipe.sv | 125 ++++++++++++
 2 files changed

// File: rtl/inst_mem_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_pipe_if
// Description : Fetch, response and load-port bundle for inst_mem_pipe.
//               master = fetch/PC stage + bootloader side,
//               slave  = instruction memory side.
// Signals     : req_valid/req_ready/req_addr  - fetch request handshake
//               flush                         - discard in-flight fetches
//               rsp_valid/rsp_ready           - response handshake
//               rsp_inst/rsp_addr/rsp_fault   - response payload
//               ld_en/ld_addr/ld_data         - word-write load port
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_mem_pipe_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_fault;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  modport master (
    output req_valid, req_addr, flush, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_fault
  );
endinterface
`default_nettype wire

// File: rtl/inst_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_pipe
// Description : Pipelined synchronous-read instruction memory with a
//               valid/ready fetch interface, LATENCY-cycle read pipeline
//               (1..4), misaligned / out-of-range fault reporting, flush,
//               and a word-write load port for bootloading.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - inst_mem_pipe_if.slave (fetch, response, load port)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_pipe #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,  // must be word aligned
  parameter int          LATENCY    = 1               // legal range 1..4
) (
  input  logic           clk,
  input  logic           rst,
  inst_mem_pipe_if.slave bus
);

  localparam int          c_depth            = 1 << DEPTH_LOG2;
  localparam logic [29:0] c_base_word        = TEXT_BASE[31:2];
  localparam logic [1:0]  c_fault_ok         = 2'b00;
  localparam logic [1:0]  c_fault_misaligned = 2'b01;
  localparam logic [1:0]  c_fault_range      = 2'b10;

  // Instruction store; deliberately not reset so loaded code survives rst.
  logic [31:0] mem [c_depth];

  // Pipeline stages; stage LATENCY-1 drives the response port.
  logic        r_valid [LATENCY];
  logic [31:0] r_addr  [LATENCY];
  logic [31:0] r_inst  [LATENCY];
  logic [1:0]  r_fault [LATENCY];

  logic [29:0]           w_req_off;
  logic [DEPTH_LOG2-1:0] w_req_idx;
  logic [1:0]            w_req_fault;
  logic [29:0]           w_ld_off;
  logic [DEPTH_LOG2-1:0] w_ld_idx;
  logic                  w_ld_we;
  logic                  w_stall;
  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_rd_en;

  // Address decode works on word offsets: with a word-aligned base the low
  // two bits of the byte offset equal addr[1:0], which only feed the
  // misalignment test. Addresses below the base wrap to a large offset and
  // therefore land in the out-of-range case automatically.
  always_comb begin
    w_req_off = bus.req_addr[31:2] - c_base_word;
    w_req_idx = w_req_off[DEPTH_LOG2-1:0];
    if (bus.req_addr[1:0] != 2'b00) begin
      w_req_fault = c_fault_misaligned;
    end else if (w_req_off[29:DEPTH_LOG2] != '0) begin
      w_req_fault = c_fault_range;
    end else begin
      w_req_fault = c_fault_ok;
    end

    w_ld_off = bus.ld_addr[31:2] - c_base_word;
    w_ld_idx = w_ld_off[DEPTH_LOG2-1:0];
    w_ld_we  = bus.ld_en && (bus.ld_addr[1:0] == 2'b00) &&
               (w_ld_off[29:DEPTH_LOG2] == '0);
  end

  // A response sitting at the output without a taker freezes every stage.
  // A flushed request is dropped even if req_ready is high, and faulted or
  // dropped requests never touch the array.
  always_comb begin
    w_stall     = r_valid[LATENCY-1] & ~bus.rsp_ready;
    w_req_ready = ~w_stall & ~rst;
    w_accept    = bus.req_valid & w_req_ready & ~bus.flush;
    w_rd_en     = w_accept & (w_req_fault == c_fault_ok);
  end

  // Load port; the non-blocking write gives read-before-write on a same-edge
  // collision with the stage-0 read below.
  always_ff @(posedge clk) begin
    if (w_ld_we) begin
      mem[w_ld_idx] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_valid[s] <= 1'b0;
        r_addr[s]  <= '0;
        r_inst[s]  <= '0;
        r_fault[s] <= '0;
      end
    end else begin
      if (!w_stall) begin
        r_valid[0] <= w_accept;
        r_addr[0]  <= bus.req_addr;
        r_fault[0] <= w_req_fault;
        r_inst[0]  <= w_rd_en ? mem[w_req_idx] : 32'h0;
        for (int s = LATENCY - 1; s > 0; s--) begin
          r_valid[s] <= r_valid[s-1];
          r_addr[s]  <= r_addr[s-1];
          r_fault[s] <= r_fault[s-1];
          r_inst[s]  <= r_inst[s-1];
        end
      end
      // Flush wins over both stall and the shift above.
      if (bus.flush) begin
        for (int s = 0; s < LATENCY; s++) begin
          r_valid[s] <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_valid[LATENCY-1];
  assign bus.rsp_inst  = r_inst[LATENCY-1];
  assign bus.rsp_addr  = r_addr[LATENCY-1];
  assign bus.rsp_fault = r_fault[LATENCY-1];

endmodule
`default_nettype wire
